// File: rtl/aukv_wb_pkg.sv
// Shared types for the AUK-V data-memory to Wishbone bridge.
// Contents: FSM state encoding, the request record carried from the core
// to the bus registers, and the all-lanes byte-select constant.
package aukv_wb_pkg;

  // Widest request the record can carry; the bridge parameters must not exceed these.
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  localparam logic [WB_SW-1:0] SEL_ALL = '1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_GAP  = 2'd2
  } bridge_state_t;

  // Request already shaped for the bus: reads carry zero data and all-ones sel.
  typedef struct packed {
    logic             we;
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [WB_SW-1:0] sel;
  } wb_req_t;

endpackage

// File: rtl/wb_req_slot.sv
// One-entry request holding register with full flag and sticky drop detection.
// Latency: written entry is visible on rd_dat_o the cycle after wr_i.
// Backpressure: none; a write into a full slot that is not read in the same cycle is dropped and flagged.
//   clk/rst     : clock, synchronous active-high reset
//   wr_i/wr_dat_i : store a request
//   rd_i        : consume the stored request (may coincide with wr_i)
//   rd_dat_o/full_o : stored request and occupancy
//   overflow_o  : sticky, set when a write was dropped
module wb_req_slot
  import aukv_wb_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    wr_i,
  input  wb_req_t wr_dat_i,
  input  logic    rd_i,
  output wb_req_t rd_dat_o,
  output logic    full_o,
  output logic    overflow_o
);

  logic    full_q, full_d;
  logic    ovf_q, ovf_d;
  wb_req_t dat_q, dat_d;

  always_comb begin
    full_d = full_q;
    ovf_d  = ovf_q;
    dat_d  = dat_q;
    if (rd_i) begin
      full_d = 1'b0;
    end
    if (wr_i) begin
      // A read in the same cycle frees the entry, so the write is accepted.
      if (full_q && !rd_i) begin
        ovf_d = 1'b1;
      end else begin
        full_d = 1'b1;
        dat_d  = wr_dat_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
      dat_q  <= dat_d;
    end
  end

  assign rd_dat_o   = dat_q;
  assign full_o     = full_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/aukv_wb_bridge.sv
// Bridges the AUK-V data-memory request pulse interface to a Wishbone B4 classic master.
// Latency: cyc/stb rise the cycle after the request; rsp_valid_o pulses the cycle after ack/err/timeout.
// Backpressure: one request buffered while busy; a further request is dropped and sets sticky overflow_o.
//   clk_core/rst_core : clock, synchronous active-high reset
//   req_*   : core request (en pulse, we, addr, data, strobe)
//   rsp_*   : response pulse, read data, error flag
//   busy_o/overflow_o : status
//   wb_*    : Wishbone master port
module aukv_wb_bridge
  import aukv_wb_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk_core,
  input  logic                    rst_core,
  input  logic                    req_en_i,
  input  logic                    req_we_i,
  input  logic [ADDR_WIDTH-1:0]   req_addr_i,
  input  logic [DATA_WIDTH-1:0]   req_data_i,
  input  logic [DATA_WIDTH/8-1:0] req_strobe_i,
  output logic                    rsp_valid_o,
  output logic [DATA_WIDTH-1:0]   rsp_data_o,
  output logic                    rsp_err_o,
  output logic                    busy_o,
  output logic                    overflow_o,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  output logic [ADDR_WIDTH-1:0]   wb_addr_o,
  output logic [DATA_WIDTH-1:0]   wb_data_o,
  input  logic [DATA_WIDTH-1:0]   wb_data_i,
  input  logic                    wb_ack_i,
  input  logic                    wb_err_i
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] CNT_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_MAX   = '1;

  bridge_state_t         state_q, state_d;
  wb_req_t               bus_q, bus_d;
  wb_req_t               req_in, pend;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  pend_full, slot_wr, slot_rd, timeout_hit;

  // Shape the incoming request for the bus once, so pending and direct paths agree.
  always_comb begin
    req_in      = '0;
    req_in.we   = req_we_i;
    req_in.addr = WB_AW'(req_addr_i);
    if (req_we_i) begin
      req_in.data = WB_DW'(req_data_i);
      req_in.sel  = WB_SW'(req_strobe_i);
    end else begin
      req_in.sel  = SEL_ALL;
    end
  end

  // A request goes to the slot whenever it cannot be loaded directly onto the bus.
  assign slot_wr = req_en_i && ((state_q != ST_IDLE) || pend_full);

  wb_req_slot u_slot (
    .clk        (clk_core),
    .rst        (rst_core),
    .wr_i       (slot_wr),
    .wr_dat_i   (req_in),
    .rd_i       (slot_rd),
    .rd_dat_o   (pend),
    .full_o     (pend_full),
    .overflow_o (overflow_o)
  );

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LIMIT);

  always_comb begin
    state_d     = state_q;
    bus_d       = bus_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    slot_rd     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_full) begin
          bus_d   = pend;
          slot_rd = 1'b1;
          cnt_d   = '0;
          state_d = ST_BUS;
        end else if (req_en_i) begin
          bus_d   = req_in;
          cnt_d   = '0;
          state_d = ST_BUS;
        end
      end
      ST_BUS: begin
        if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
        if (wb_ack_i || wb_err_i || timeout_hit) begin
          state_d     = ST_GAP;
          rsp_valid_d = 1'b1;
          // err beats ack, ack beats a coincident timeout.
          rsp_err_d   = wb_err_i || !wb_ack_i;
          if (wb_ack_i && !wb_err_i && !bus_q.we) begin
            rsp_data_d = wb_data_i;
          end
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_core) begin
    if (rst_core) begin
      state_q     <= ST_IDLE;
      bus_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      bus_q       <= bus_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign wb_cyc_o    = (state_q == ST_BUS);
  assign wb_stb_o    = (state_q == ST_BUS);
  assign wb_we_o     = bus_q.we;
  assign wb_sel_o    = bus_q.sel[SW-1:0];
  assign wb_addr_o   = bus_q.addr[ADDR_WIDTH-1:0];
  assign wb_data_o   = bus_q.data[DATA_WIDTH-1:0];
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_err_o   = rsp_err_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (state_q != ST_IDLE) || pend_full;

endmodule

// File: doc/aukv_wb_bridge.md
# aukv_wb_bridge

Converts the AUK-V core's data-memory request interface (enable pulse, write-enable, address, data, byte strobe; expects a valid-qualified response) into a Wishbone B4 classic master cycle toward the Controller's data memory port. It sits directly downstream of the core, in place of the tie-offs that force `cyc` and `stb` permanently high. It adds the following:
- a one-entry pending buffer;
- a bus timeout;
- an error-flagged response path.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width (byte lanes = DATA_WIDTH/8)
- `TIMEOUT_CYCLES`, 255, maximum cycles waiting for ack/err; 0 disables timeout
- `clk_core`  in  1  core clock; all logic on rising edge
- `rst_core`  in  1  reset; synchronous, active-high
- `req_en_i`  in  1  one-cycle request pulse from core
- `req_we_i`  in  1  1 = write
- `req_addr_i`  in  ADDR_WIDTH  byte address
- `req_data_i`  in  DATA_WIDTH  write data
- `req_strobe_i`  in  DATA_WIDTH/8  write byte enables
- `rsp_valid_o`  out  1  one-cycle response pulse to core
- `rsp_data_o`  out  DATA_WIDTH  read data (0 for writes and errors)
- `rsp_err_o`  out  1  qualifies `rsp_valid_o`; bus error or timeout
- `busy_o`  out  1  transfer in progress or pending entry occupied
- `overflow_o`  out  1  sticky; request dropped because the pending buffer was full
- `wb_cyc_o`, `wb_stb_o`, `wb_we_o`  out  1  Wishbone master controls
- `wb_sel_o`  out  DATA_WIDTH/8  byte selects
- `wb_addr_o`  out  ADDR_WIDTH  address
- `wb_data_o`  out  DATA_WIDTH  write data
- `wb_data_i`  in  DATA_WIDTH  read data
- `wb_ack_i`, `wb_err_i`  in  1  slave termination

## Operation
- **FSM states:** IDLE, BUS, GAP.
- **IDLE:** a request enters BUS at the next edge. The request source is the pending entry if occupied, else `req_en_i`; pending has priority. Bus registers load:
  - `wb_addr_o` = address;
  - `wb_we_o` = `req_we_i`;
  - `wb_data_o` = write data (0 for reads);
  - `wb_sel_o` = strobe for writes, all-ones for reads.
- **BUS:** `wb_cyc_o` = `wb_stb_o` = 1. The cycle counter increments each cycle. Termination is on `wb_ack_i`, `wb_err_i`, or counter == TIMEOUT_CYCLES (when TIMEOUT_CYCLES ≠ 0). On termination:
  - go to GAP;
  - drop `cyc`/`stb` at that edge;
  - pulse `rsp_valid_o` in the next cycle.
- **GAP:** one cycle with `cyc` low, guaranteeing idle time between transfers for the non-pipelined slave. Then go to IDLE.
- **Response contents:**
  - ack on a read: `rsp_data_o` = `wb_data_i` sampled on the ack edge, `rsp_err_o` = 0.
  - ack on a write: `rsp_data_o` = 0, `rsp_err_o` = 0.
  - err or timeout: `rsp_data_o` = 0, `rsp_err_o` = 1.
- **Pending buffer:** a `req_en_i` arriving while not in IDLE, or in IDLE with pending already occupied, is stored in the pending entry if empty. If the entry is full, the request is dropped and `overflow_o` is set until reset.
- **`busy_o`:** `busy_o` = (state ≠ IDLE) | pending occupied.

## Timing
- **Reset:** every output is 0 at the first edge with `rst_core` = 1. State = IDLE, pending cleared, counter = 0, `overflow_o` cleared. Reset mid-transfer aborts it: `cyc` drops and no response is issued.
- **Latency:** request pulse at edge N gives `cyc`/`stb` high from N+1. Ack sampled at edge K gives `cyc` low and `rsp_valid_o` high in the cycle after K. Zero-wait slave: 2 cycles request-to-response.
- **Back-to-back:** the next bus cycle starts ≥ 2 cycles after the previous ack (GAP + IDLE load). `wb_*` outputs are stable for the whole of BUS.
- **Simultaneous events:**
  - `wb_ack_i` and `wb_err_i` together: err wins.
  - Ack in the same cycle the counter hits its limit: ack wins.
  - Request in the same cycle pending drains in IDLE: the new request is written to pending, with no drop.
- **Counter width:** $clog2(TIMEOUT_CYCLES+1). Cleared on BUS entry; saturates, never wraps.

## Structure
- Package `aukv_wb_pkg`:
  - `bridge_state_t` enum;
  - `wb_req_t` struct (we, addr, data, sel);
  - `SEL_ALL` constant.
- Sub-module `wb_req_slot`: a one-entry request buffer with write, read and full flag, and overflow detection.

## Test plan
- **Zero-wait read:** read to 0x0000_0100; slave acks on the first BUS cycle with 0xDEAD_BEEF → `rsp_valid_o` 2 cycles after the request, `rsp_data_o` = 0xDEAD_BEEF, `rsp_err_o` = 0.
- **Write with wait states:** write 0x1234_5678, strobe 4'b0011; ack after 5 wait cycles → `wb_sel_o` = 0011 and `wb_data_o` stable for 6 cycles; response data 0, err 0.
- **Timeout:** TIMEOUT_CYCLES = 8, slave never responds → `cyc` drops after 9 BUS cycles; `rsp_err_o` = 1, `rsp_data_o` = 0.
- **Buffering:** three requests on consecutive cycles while the first stalls → second served after the first with ≥ 1 `cyc`-low cycle between; third dropped, `overflow_o` = 1, exactly 2 responses.
- **Error:** `wb_err_i` and `wb_ack_i` asserted together → `rsp_err_o` = 1.
- **Reset mid-BUS:** `rst_core` pulse → all outputs 0 next edge, no `rsp_valid_o`, pending discarded; a fresh request afterwards completes normally.
